// File: rtl/bus_register_bank.sv
// Bank of DEPTH registers on one shared tri-state bus: one latch, one drive and
// one in-place increment/decrement per cycle, with a sticky error flag.
module bus_register_bank #(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter int               ADDR_W    = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire  [WIDTH-1:0]  DATA,
  input  logic              latch,
  input  logic [ADDR_W-1:0] latch_addr,
  input  logic              enable,
  input  logic [ADDR_W-1:0] enable_addr,
  input  logic              step_inc,
  input  logic              step_dec,
  input  logic [ADDR_W-1:0] step_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic              err,
  output logic [ADDR_W-1:0] last_latched
);

  localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic [WIDTH-1:0]  regs_d [DEPTH];
  logic              err_q, err_d;
  logic [ADDR_W-1:0] last_latched_q, last_latched_d;

  logic              en_ok, latch_ok, step_ok;
  logic              step_req, step_one, latch_go;
  logic [WIDTH-1:0]  bus_drv;

  assign en_ok    = {1'b0, enable_addr} < DEPTH_C;
  assign latch_ok = {1'b0, latch_addr}  < DEPTH_C;
  assign step_ok  = {1'b0, step_addr}   < DEPTH_C;
  assign step_req = step_inc | step_dec;
  assign step_one = (step_inc ^ step_dec) & step_ok;
  assign latch_go = latch & latch_ok;

  // Read muxes; an out-of-range select matches nothing and yields zero.
  always_comb begin
    bus_drv  = '0;
    dbg_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (enable_addr == ADDR_W'(i)) bus_drv  = regs_q[i];
      if (dbg_addr    == ADDR_W'(i)) dbg_data = regs_q[i];
    end
  end

  assign DATA = (enable && en_ok) ? bus_drv : {WIDTH{1'bz}};

  always_comb begin
    regs_d         = regs_q;
    err_d          = err_q;
    last_latched_d = last_latched_q;

    if (enable && !en_ok)                                 err_d = 1'b1;
    if (step_req && ((step_inc && step_dec) || !step_ok)) err_d = 1'b1;
    if (latch && !latch_ok)                               err_d = 1'b1;

    // Step first, then latch, so a latch on the same register overrides the step.
    for (int i = 0; i < DEPTH; i++) begin
      if (step_one && step_addr == ADDR_W'(i))
        regs_d[i] = step_inc ? regs_q[i] + ONE : regs_q[i] - ONE;
      if (latch_go && latch_addr == ADDR_W'(i))
        regs_d[i] = DATA;
    end

    if (latch_go) last_latched_d = latch_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= RESET_VAL;
      err_q          <= 1'b0;
      last_latched_q <= '0;
    end else begin
      regs_q         <= regs_d;
      err_q          <= err_d;
      last_latched_q <= last_latched_d;
    end
  end

  assign err          = err_q;
  assign last_latched = last_latched_q;

endmodule
